seg_scan_driver: RTL

Time-multiplexed seven-segment scan driver sitting directly downstream of the BCD converter: it consumes the five 4-bit digit codes (D5..D1) and drives one shared segment bus plus five digit enables, one digit per scan slot. It snapshots all five digits once per frame, so a hash or time update mid-frame never produces a torn display. It decodes glyphs, applies optional leading-zero blanking and inserts an anti-ghosting blank interval at each digit switch.

---
 rtl/seg_scan_driver.sv | 133 +++++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// Five-digit time-multiplexed seven-segment scan driver.
// Snapshots D5..D1 once per frame, decodes the selected digit to a glyph and
// inserts a blank interval at the start of every digit slot.
// Optional feature macro: LEADING_ZERO_BLANK_EN (darkens leading zeros on D5..D2).
`timescale 1ns/1ps

module seg_scan_driver #(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned BLANK_CYCLES = 8
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic [3:0] D5_in,
    input  logic [3:0] D4_in,
    input  logic [3:0] D3_in,
    input  logic [3:0] D2_in,
    input  logic [3:0] D1_in,
    output logic [6:0] seg,
    output logic [4:0] an,
    output logic       frame_start
);

    localparam int unsigned T_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CODE_W = 4;
    localparam int unsigned NDIG   = 5;

    logic [T_W-1:0]                t_cnt;
    logic [2:0]                    dig_idx;
    logic [NDIG-1:0][CODE_W-1:0]   shadow;     // [4]=D5 .. [0]=D1

    logic                          t_wrap_c;
    logic                          snap_c;
    logic [NDIG-1:0]               lz_blank_c;
    logic [CODE_W-1:0]             cur_code_c;
    logic                          cur_lz_c;
    logic [NDIG-1:0]               onehot_c;
    logic [6:0]                    glyph_c;
    logic [NDIG-1:0]               an_c;
    logic [6:0]                    seg_c;

    // Slot-counter wrap and frame snapshot strobe
    always_comb begin
        t_wrap_c = (t_cnt == T_W'(SCAN_DIV - 1));
        snap_c   = (t_cnt == '0) && (dig_idx == 3'd0);
    end

`ifdef LEADING_ZERO_BLANK_EN
    function automatic logic zero_or_blank(input logic [CODE_W-1:0] c);
        return (c == 4'd0) || (c == 4'd15);
    endfunction

    // Leading-zero detection on the frame snapshot; D1 always shows
    always_comb begin
        lz_blank_c    = '0;
        lz_blank_c[4] = (shadow[4] == 4'd0);
        lz_blank_c[3] = (shadow[3] == 4'd0) && zero_or_blank(shadow[4]);
        lz_blank_c[2] = (shadow[2] == 4'd0) && zero_or_blank(shadow[4])
                        && zero_or_blank(shadow[3]);
        lz_blank_c[1] = (shadow[1] == 4'd0) && zero_or_blank(shadow[4])
                        && zero_or_blank(shadow[3]) && zero_or_blank(shadow[2]);
    end
`else
    assign lz_blank_c = '0;
`endif

    // Select the active digit's code, blank flag and enable position
    always_comb begin
        cur_code_c = 4'd15;
        cur_lz_c   = 1'b0;
        onehot_c   = '0;
        case (dig_idx)
            3'd0: begin cur_code_c = shadow[0]; cur_lz_c = lz_blank_c[0]; onehot_c = 5'b00001; end
            3'd1: begin cur_code_c = shadow[1]; cur_lz_c = lz_blank_c[1]; onehot_c = 5'b00010; end
            3'd2: begin cur_code_c = shadow[2]; cur_lz_c = lz_blank_c[2]; onehot_c = 5'b00100; end
            3'd3: begin cur_code_c = shadow[3]; cur_lz_c = lz_blank_c[3]; onehot_c = 5'b01000; end
            3'd4: begin cur_code_c = shadow[4]; cur_lz_c = lz_blank_c[4]; onehot_c = 5'b10000; end
            default: ;
        endcase
    end

    // Glyph decode: decimal digits, dash for 10..14, dark for 15
    always_comb begin
        glyph_c = 7'h00;
        case (cur_code_c)
            4'd0:  glyph_c = 7'h3F;
            4'd1:  glyph_c = 7'h06;
            4'd2:  glyph_c = 7'h5B;
            4'd3:  glyph_c = 7'h4F;
            4'd4:  glyph_c = 7'h66;
            4'd5:  glyph_c = 7'h6D;
            4'd6:  glyph_c = 7'h7D;
            4'd7:  glyph_c = 7'h07;
            4'd8:  glyph_c = 7'h7F;
            4'd9:  glyph_c = 7'h6F;
            4'd15: glyph_c = 7'h00;
            default: glyph_c = 7'h40;
        endcase
    end

    // Next slot output: dark during the anti-ghost interval or for blanked digits
    always_comb begin
        an_c  = '0;
        seg_c = '0;
        if ((t_cnt >= T_W'(BLANK_CYCLES)) && (cur_code_c != 4'd15) && !cur_lz_c) begin
            an_c  = onehot_c;
            seg_c = glyph_c;
        end
    end

    // Counters, frame snapshot and registered outputs
    always_ff @(posedge sysclk) begin
        if (reset) begin
            t_cnt       <= '0;
            dig_idx     <= 3'd0;
            shadow      <= '0;
            an          <= '0;
            seg         <= '0;
            frame_start <= 1'b0;
        end else begin
            t_cnt <= t_wrap_c ? '0 : t_cnt + T_W'(1);
            if (t_wrap_c) begin
                dig_idx <= (dig_idx == 3'd4) ? 3'd0 : dig_idx + 3'd1;
            end
            if (snap_c) begin
                shadow <= {D5_in, D4_in, D3_in, D2_in, D1_in};
            end
            frame_start <= snap_c;
            an          <= an_c;
            seg         <= seg_c;
        end
    end

endmodule
